// File: rtl/pacman_mover.sv
// Sprite motion controller: buffered turns, tick-paced steps, wall queries via req/ack.
// Define PACMAN_TUNNEL_WRAP_EN to make x wrap around instead of clamping at the edges.
module pacman_mover #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int X_INIT   = 80,
  parameter int Y_INIT   = 60,
  parameter int STEP     = 1,
  parameter int MOVE_DIV = 833333
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic [2:0]     dir_in,
  input  logic           dir_valid,
  output logic           wall_req,
  output logic [X_W-1:0] wall_x,
  output logic [Y_W-1:0] wall_y,
  input  logic           wall_ack,
  input  logic           wall_hit,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     heading,
  output logic           moving,
  output logic           step_done
);

  localparam int CW = $clog2(MOVE_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(MOVE_DIV - 1);
  localparam logic [X_W:0]  STEP_X   = (X_W+1)'(STEP);
  localparam logic [X_W:0]  XMAX_X   = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]  STEP_Y   = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]  YMAX_Y   = (Y_W+1)'(Y_MAX);
`ifdef PACMAN_TUNNEL_WRAP_EN
  localparam logic [X_W:0]  XLIM_X   = (X_W+1)'(X_MAX + 1);
`endif

  localparam logic [2:0] DIR_R    = 3'd0;
  localparam logic [2:0] DIR_U    = 3'd1;
  localparam logic [2:0] DIR_L    = 3'd2;
  localparam logic [2:0] DIR_D    = 3'd3;
  localparam logic [2:0] DIR_STOP = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_CHK_PEND, S_CHK_HEAD, S_MOVE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [X_W-1:0] x_q, wall_x_q;
  logic [Y_W-1:0] y_q, wall_y_q;
  logic [2:0]     heading_q, turn_q, pend_dir_q, pend_dir_d;
  logic           pend_vld_q, pend_vld_d;
  logic           wall_req_q, step_done_q;

  logic           tick, pend_clr, cand_blocked;
  logic [2:0]     chk_dir;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;

  assign tick = enable && (cnt_q == DIV_LAST);

  // Candidate is computed one bit wide so edge under/overflow is visible before clamping.
  always_comb begin
    chk_dir = (state_q == S_CHK_PEND) ? pend_dir_q : heading_q;
    sum_x   = {1'b0, x_q} + STEP_X;
    sum_y   = {1'b0, y_q} + STEP_Y;
    cand_x  = x_q;
    cand_y  = y_q;
    case (chk_dir)
      DIR_R: begin
        if (sum_x > XMAX_X) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          cand_x = X_W'(sum_x - XLIM_X);
`else
          cand_x = X_W'(XMAX_X);
`endif
        end else begin
          cand_x = X_W'(sum_x);
        end
      end
      DIR_L: begin
        if ({1'b0, x_q} < STEP_X) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          cand_x = X_W'({1'b0, x_q} + XLIM_X - STEP_X);
`else
          cand_x = '0;
`endif
        end else begin
          cand_x = X_W'({1'b0, x_q} - STEP_X);
        end
      end
      DIR_U: begin
        if ({1'b0, y_q} < STEP_Y) cand_y = '0;
        else                      cand_y = Y_W'({1'b0, y_q} - STEP_Y);
      end
      DIR_D: begin
        if (sum_y > YMAX_Y) cand_y = Y_W'(YMAX_Y);
        else                cand_y = Y_W'(sum_y);
      end
      default: ;
    endcase
    cand_blocked = (cand_x == x_q) && (cand_y == y_q);
  end

  // A new request in the same cycle the pending turn is consumed overrides the clear.
  always_comb begin
    pend_clr = ((state_q == S_IDLE) && tick && pend_vld_q &&
                ((pend_dir_q == DIR_STOP) || (pend_dir_q == heading_q))) ||
               ((state_q == S_CHK_PEND) && wall_req_q && wall_ack && !wall_hit);
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    if (pend_clr) pend_vld_d = 1'b0;
    if (dir_valid && (dir_in <= DIR_STOP)) begin
      pend_vld_d = 1'b1;
      pend_dir_d = dir_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= X_W'(X_INIT);
      y_q         <= Y_W'(Y_INIT);
      heading_q   <= DIR_STOP;
      turn_q      <= DIR_STOP;
      pend_dir_q  <= DIR_STOP;
      pend_vld_q  <= 1'b0;
      wall_req_q  <= 1'b0;
      wall_x_q    <= '0;
      wall_y_q    <= '0;
      step_done_q <= 1'b0;
    end else begin
      cnt_q       <= (!enable || (cnt_q == DIV_LAST)) ? '0 : cnt_q + 1'b1;
      pend_vld_q  <= pend_vld_d;
      pend_dir_q  <= pend_dir_d;
      step_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            if (pend_vld_q && (pend_dir_q == DIR_STOP)) heading_q <= DIR_STOP;
            else if (pend_vld_q && (pend_dir_q != heading_q)) state_q <= S_CHK_PEND;
            else if (heading_q != DIR_STOP) state_q <= S_CHK_HEAD;
          end
        end
        S_CHK_PEND: begin
          if (!wall_req_q) begin
            if (cand_blocked) begin
              state_q <= (heading_q != DIR_STOP) ? S_CHK_HEAD : S_IDLE;
            end else begin
              wall_req_q <= 1'b1;
              wall_x_q   <= cand_x;
              wall_y_q   <= cand_y;
              turn_q     <= pend_dir_q;
            end
          end else if (wall_ack) begin
            wall_req_q <= 1'b0;
            if (!wall_hit) begin
              heading_q <= turn_q;
              state_q   <= S_MOVE;
            end else begin
              state_q <= (heading_q != DIR_STOP) ? S_CHK_HEAD : S_IDLE;
            end
          end
        end
        S_CHK_HEAD: begin
          if (!wall_req_q) begin
            if (cand_blocked) begin
              heading_q <= DIR_STOP;
              state_q   <= S_IDLE;
            end else begin
              wall_req_q <= 1'b1;
              wall_x_q   <= cand_x;
              wall_y_q   <= cand_y;
            end
          end else if (wall_ack) begin
            wall_req_q <= 1'b0;
            if (!wall_hit) begin
              state_q <= S_MOVE;
            end else begin
              heading_q <= DIR_STOP;
              state_q   <= S_IDLE;
            end
          end
        end
        S_MOVE: begin
          x_q         <= wall_x_q;
          y_q         <= wall_y_q;
          step_done_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wall_req  = wall_req_q;
  assign wall_x    = wall_x_q;
  assign wall_y    = wall_y_q;
  assign x         = x_q;
  assign y         = y_q;
  assign heading   = heading_q;
  assign moving    = (heading_q != DIR_STOP);
  assign step_done = step_done_q;

endmodule
